// File: rtl/display_scan_driver_pkg.sv
// display_pkg: constants, phase type and small helpers shared by the display blocks.
//   SEG_BLANK  - active-low segment pattern with every segment dark
//   ANODE_OFF  - active-low anode pattern with every digit dark
//   scan_phase_e - phase of the current digit slot (blanking gap or lit)
//   anode_sel  - active-low one-hot anode pattern for a digit index
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } scan_phase_e;

  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_scan_driver_hex_to_7seg.sv
// hex_to_7seg: purely combinational nibble -> 7-segment pattern.
//   nibble  in  4  hex value 0..F
//   seg     out 7  active-low cathodes, order {g,f,e,d,c,b,a}
// Glyphs for b and d are lowercase so they cannot be confused with 8 and 0.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Nibble to glyph lookup
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display.
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   digits       in  16   four nibbles, [3:0] = digit 0 (rightmost)
//   dp_en        in   4   per-digit decimal point enable, active-high
//   digit_en     in   4   per-digit enable, active-high
//   anode_out    out  4   active-low one-hot digit select
//   seg_out      out  7   active-low cathodes {g,f,e,d,c,b,a}
//   dp_out       out  1   active-low decimal point
//   frame_start  out  1   one-cycle pulse at the start of each digit-0 slot
// Each slot of REFRESH_DIV cycles starts with a blanking gap. Segments are
// loaded on the edge leaving slot_cnt==0 and the anode is switched on only on
// the edge leaving slot_cnt==BLANK_CYCLES, so the cathodes are always settled
// before a digit lights and never change while one is lit.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic [3:0]  digit_en,
  output logic [3:0]  anode_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] slot_cnt_r;
  logic [1:0]       idx_r;
  scan_phase_e      phase_r;
  logic             run_r;
  logic [3:0]       anode_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic             frame_start_r;

  logic [3:0]       nibble_s;
  logic [6:0]       glyph_s;
  logic             slot_last_s;

  // Select the nibble of the digit currently being scanned
  always_comb begin
    nibble_s = digits[3:0];
    case (idx_r)
      2'd0:    nibble_s = digits[3:0];
      2'd1:    nibble_s = digits[7:4];
      2'd2:    nibble_s = digits[11:8];
      2'd3:    nibble_s = digits[15:12];
      default: nibble_s = digits[3:0];
    endcase
  end

  hex_to_7seg u_decode (
    .nibble (nibble_s),
    .seg    (glyph_s)
  );

  assign slot_last_s = (slot_cnt_r == CNT_LAST);

  // Slot counter, digit index, phase and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r    <= CNT_ZERO;
      idx_r         <= 2'd0;
      phase_r       <= PH_BLANK;
      run_r         <= 1'b0;
      anode_r       <= ANODE_OFF;
      seg_r         <= SEG_BLANK;
      dp_r          <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      run_r         <= 1'b1;
      // First cycle after reset release also counts as a frame start,
      // since scanning begins at digit 0, slot 0.
      frame_start_r <= (!run_r) || (slot_last_s && (idx_r == 2'd3));
      if (slot_last_s) begin
        slot_cnt_r <= CNT_ZERO;
        idx_r      <= idx_r + 2'd1;
        phase_r    <= PH_BLANK;
        anode_r    <= ANODE_OFF;
      end else begin
        slot_cnt_r <= slot_cnt_r + CNT_ONE;
        // Inputs are sampled once per slot so mid-slot changes cannot tear
        if (slot_cnt_r == CNT_ZERO) begin
          seg_r <= glyph_s;
          dp_r  <= ~dp_en[idx_r];
        end else begin
          seg_r <= seg_r;
          dp_r  <= dp_r;
        end
        if ((slot_cnt_r == CNT_BLANK) && (phase_r == PH_BLANK)) begin
          phase_r <= PH_ON;
          anode_r <= digit_en[idx_r] ? anode_sel(idx_r) : ANODE_OFF;
        end else begin
          phase_r <= phase_r;
          anode_r <= anode_r;
        end
      end
    end
  end

  assign anode_out   = anode_r;
  assign seg_out     = seg_r;
  assign dp_out      = dp_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver. Instance A uses REFRESH_DIV=8,
// BLANK_CYCLES=2; instance B uses the REFRESH_DIV=4, BLANK_CYCLES=1 corner.
module tb_display_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        rst_b;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic [3:0]  digit_en;

  logic [3:0]  an_a;
  logic [6:0]  seg_a;
  logic        dp_a;
  logic        fs_a;
  logic [3:0]  an_b;
  logic [6:0]  seg_b;
  logic        dp_b;
  logic        fs_b;

  int errors = 0;
  int checks = 0;
  int k = 0;

  // expected state for instance A, updated by the edge the DUT samples on
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;

  display_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits      (digits),
    .dp_en       (dp_en),
    .digit_en    (digit_en),
    .anode_out   (an_a),
    .seg_out     (seg_a),
    .dp_out      (dp_a),
    .frame_start (fs_a)
  );

  display_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut_b (
    .clk         (clk),
    .rst_n       (rst_b),
    .digits      (digits),
    .dp_en       (dp_en),
    .digit_en    (digit_en),
    .anode_out   (an_b),
    .seg_out     (seg_b),
    .dp_out      (dp_b),
    .frame_start (fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (k=%0d): observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  // One clock of instance A with full per-cycle checking
  task automatic tick_a();
    int c;
    int s;
    logic [6:0] prev_seg;
    logic [3:0] prev_an;
    c = k % 8;
    s = (k / 8) % 4;
    if (c == 0) begin
      m_seg = glyph(digits[s*4 +: 4]);
      m_dp  = ~dp_en[s];
    end
    if (c == 2) m_an = digit_en[s] ? ~(4'b0001 << s) : 4'b1111;
    if (c == 7) m_an = 4'b1111;
    prev_seg = seg_a;
    prev_an  = an_a;
    @(posedge clk);
    #1;
    k++;
    check("anode", {12'd0, an_a}, {12'd0, m_an});
    check("seg", {9'd0, seg_a}, {9'd0, m_seg});
    check("dp", {15'd0, dp_a}, {15'd0, m_dp});
    check("frame_start", {15'd0, fs_a}, {15'd0, (k == 1) || (k % 32 == 0)});
    if ((prev_an != 4'b1111) || (an_a != 4'b1111))
      check("seg_stable_lit", {9'd0, seg_a}, {9'd0, prev_seg});
  endtask

  initial begin
    int j;
    int lows;
    int s;
    logic [3:0] exp_an;
    rst_n    = 1'b1;
    rst_b    = 1'b1;
    digits   = 16'h4321;
    dp_en    = 4'h0;
    digit_en = 4'hF;
    #2;
    rst_n = 1'b0;
    rst_b = 1'b0;
    #2;
    check("rst_anode", {12'd0, an_a}, 16'h000F);
    check("rst_seg", {9'd0, seg_a}, 16'h007F);
    check("rst_dp", {15'd0, dp_a}, 16'h0001);
    check("rst_fs", {15'd0, fs_a}, 16'h0000);
    check("rst_anode_b", {12'd0, an_b}, 16'h000F);

    // Idle scan of 4321, two frames
    m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; k = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick_a();
      if (k == 1) check("digit0_is_1", {9'd0, seg_a}, 16'h0079);
      if (k == 3) check("digit0_lit", {12'd0, an_a}, 16'h000E);
      if (k == 11) check("digit1_lit", {12'd0, an_a}, 16'h000D);
    end

    // Glyph corners: 8 and F
    digits = 16'hF0A8;
    for (int i = 0; i < 32; i++) begin
      tick_a();
      if (k == 65) check("digit0_is_8", {9'd0, seg_a}, 16'h0000);
      if (k == 89) check("digit3_is_F", {9'd0, seg_a}, 16'h000E);
    end

    // Change digits mid-ON of digit 1 (slot_cnt=5 at k=109)
    while (k < 109) tick_a();
    digits = 16'h1234;
    while (k < 160) begin
      tick_a();
      if (k == 111) check("no_tearing", {9'd0, seg_a}, 16'h0008);
      if (k == 137) check("new_digit1", {9'd0, seg_a}, 16'h0030);
    end

    // Digit 2 disabled, decimal point only on digit 2
    digit_en = 4'b1011;
    dp_en    = 4'b0100;
    while (k < 203) begin
      tick_a();
      if (k == 180) check("digit2_dark", {12'd0, an_a}, 16'h000F);
      if (k == 177) check("dp_digit2", {15'd0, dp_a}, 16'h0000);
      if (k == 169) check("dp_digit1", {15'd0, dp_a}, 16'h0001);
    end

    // Asynchronous reset mid-slot, away from any clock edge
    check("pre_rst_lit", {12'd0, an_a}, 16'h000D);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_anode", {12'd0, an_a}, 16'h000F);
    check("async_rst_seg", {9'd0, seg_a}, 16'h007F);
    check("async_rst_dp", {15'd0, dp_a}, 16'h0001);
    digit_en = 4'hF;
    dp_en    = 4'h0;
    m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; k = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) begin
      tick_a();
      if (k == 1) check("restart_fs", {15'd0, fs_a}, 16'h0001);
      if (k == 3) check("restart_digit0", {12'd0, an_a}, 16'h000E);
    end

    // Boundary instance: REFRESH_DIV=4, BLANK_CYCLES=1, three frames
    @(negedge clk);
    rst_b = 1'b1;
    j = 0;
    lows = 0;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk);
      #1;
      j++;
      s = (j / 4) % 4;
      exp_an = ((j % 4) >= 2) ? ~(4'b0001 << s) : 4'b1111;
      if (an_b != 4'b1111) lows++;
      check("b_anode", {12'd0, an_b}, {12'd0, exp_an});
      check("b_fs", {15'd0, fs_b}, {15'd0, (j == 1) || (j % 16 == 0)});
      if ((j % 4) != 0) check("b_seg", {9'd0, seg_b}, {9'd0, glyph(digits[s*4 +: 4])});
    end
    check("b_low_cycles", lows[15:0], 16'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Time-multiplexed driver for the 4-digit common-anode 7-segment display.
- Scans four hex/BCD nibbles one digit at a time and produces the active-low anode select and the active-low segment and decimal-point cathodes.
- anode_out is the source that downstream blink gating receives as its anode input. segments and dp go straight to the pins.
- Inserts a blanking gap at each digit change to suppress ghosting.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. Must be > BLANK_CYCLES+1.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Must be >= 1.
- CNT_W, $clog2(REFRESH_DIV): width of the slot counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- digits  input  16  four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3
- dp_en  input  4  per-digit decimal point enable, active-high
- digit_en  input  4  per-digit enable, active-high; 0 keeps that digit dark for its whole slot
- anode_out  output  4  active-low one-hot digit select; 4'b1111 = all off
- seg_out  output  7  active-low cathodes, order {g,f,e,d,c,b,a}
- dp_out  output  1  active-low decimal point
- frame_start  output  1  one-cycle pulse at the start of each digit-0 slot

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All state is reset asynchronously.
- Reset values:
  - slot_cnt=0, idx=0
  - anode_out=4'b1111, seg_out=7'b1111111, dp_out=1, frame_start=0
- Outputs: all are registered, with no combinational path from inputs to outputs.
- Slot counter: slot_cnt counts 0..REFRESH_DIV-1 and then wraps to 0. idx (2 bits) selects the current digit.
- Phases within a slot:
  - BLANK: slot_cnt 0..BLANK_CYCLES.
  - ON: slot_cnt BLANK_CYCLES+1..REFRESH_DIV-1.
- Edge leaving slot_cnt==0:
  - seg_out <= decode(digits[idx*4+:4]).
  - dp_out <= ~dp_en[idx].
  - These are the only cycles where digits/dp_en are sampled. Input changes mid-slot do not alter the lit digit; no tearing.
- Edge leaving slot_cnt==BLANK_CYCLES:
  - anode_out <= ~(4'b0001 << idx) if digit_en[idx], else 4'b1111.
  - digit_en is sampled here only.
- Edge leaving slot_cnt==REFRESH_DIV-1:
  - anode_out <= 4'b1111, slot_cnt <= 0, idx <= idx+1 (3 wraps to 0).
  - seg_out and dp_out hold their value. Anodes are off, so nothing is visible.
- Resulting timing: anode low for exactly REFRESH_DIV-1-BLANK_CYCLES cycles per slot. Full frame = 4*REFRESH_DIV cycles.
- Segment/anode ordering: segments change at least BLANK_CYCLES cycles before the new anode asserts. No anode is ever low while seg_out changes.
- frame_start: 1 for exactly the cycle after the edge where idx goes 3->0. It is also 1 on the first cycle after reset release, since idx=0 and slot_cnt=0.
- Decode table:
  - 0-9 map to standard digits; A-F map to hex glyphs (b, d lowercase).
  - 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110.
- Reset mid-scan: immediately forces the reset values. Scanning restarts at digit 0, slot_cnt 0.
- Arithmetic: slot_cnt is unsigned CNT_W bits. Wrap uses an explicit compare to REFRESH_DIV-1, not natural overflow.

Decomposition:
- Package display_pkg:
  - SEG_BLANK = 7'b1111111 and ANODE_OFF = 4'b1111 constants.
  - scan_phase_e enum {PH_BLANK, PH_ON} used for the phase register.
- Sub-module hex_to_7seg: purely combinational nibble -> 7-bit active-low pattern. Shared with other display blocks.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2 unless noted):
- Reset, then idle with digits=16'h4321, dp_en=0, digit_en=4'hF:
  - anode_out sequence per 8-cycle slot is 1111 x3, then 1110 x5, then the next digit.
  - seg_out for digit 0 = 7'b1111001 ("1").
  - frame_start pulses every 32 cycles.
- digits=16'hF0A8:
  - digit 0 -> 7'b0000000 ("8"), digit 3 -> 7'b0001110 ("F").
  - Checker asserts seg_out is stable whenever anode_out != 4'b1111.
- Change digits mid-ON of digit 1 (slot_cnt=5):
  - seg_out is unchanged until the next digit-1 slot, where the new value appears.
- digit_en=4'b1011, dp_en=4'b0100:
  - anode_out stays 1111 for the whole digit-2 slot.
  - dp_out=0 only while digit-2 segments are loaded.
- Assert rst_n low asynchronously mid-slot (no clk edge):
  - anode_out=1111 and seg_out=7'b1111111 immediately.
  - After release, scanning restarts with digit 0 and frame_start=1.
- REFRESH_DIV=4, BLANK_CYCLES=1 boundary:
  - anode low exactly 2 cycles per slot; idx wraps 3->0 cleanly over 3 frames.
